// File: rtl/scanout_pkg.sv
// Shared constants for the trace pixel buffer scan-out: pixel codes, palette
// colours and default 640x480 VGA timing.
package scanout_pkg;

  localparam logic [1:0] CODE_WHITE   = 2'b00;
  localparam logic [1:0] CODE_TRACE1  = 2'b01;
  localparam logic [1:0] CODE_TRACE2  = 2'b10;
  localparam logic [1:0] CODE_SPECIAL = 2'b11;

  localparam logic [23:0] RGB_WHITE   = 24'hFF_FF_FF;
  localparam logic [23:0] RGB_TRACE1  = 24'h00_00_FF;
  localparam logic [23:0] RGB_TRACE2  = 24'hFF_00_00;
  localparam logic [23:0] RGB_SPECIAL = 24'h00_00_00;
  localparam logic [23:0] GRID_RGB    = 24'hC0_C0_C0;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  localparam int unsigned GRID_CENTER_X = 320;
  localparam int unsigned GRID_CENTER_Y = 240;

  function automatic logic [23:0] palette(input logic [1:0] code);
    case (code)
      CODE_WHITE:   palette = RGB_WHITE;
      CODE_TRACE1:  palette = RGB_TRACE1;
      CODE_TRACE2:  palette = RGB_TRACE2;
      default:      palette = RGB_SPECIAL;
    endcase
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters for VGA scan-out: h/v position, active-video flag, raw
// active-low syncs and the (0,0) frame-start pulse.
module vga_timing_gen
  import scanout_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] h_cnt,
  output logic [8:0] v_pos,
  output logic       active,
  output logic       hs,
  output logic       vs,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_ACT_END = 10'(H_ACTIVE);
  localparam logic [9:0] HS_BEGIN  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_ACT_END = 10'(V_ACTIVE);
  localparam logic [9:0] VS_BEGIN  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] v_cnt;
  logic       running;

  // The first edge after reset only arms the scan, so (0,0) is issued
  // exactly once, together with frame_start, one cycle after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      running <= 1'b0;
    end else if (!running) begin
      running <= 1'b1;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  assign v_pos       = v_cnt[8:0];
  assign active      = running && (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
  assign hs          = !((h_cnt >= HS_BEGIN) && (h_cnt < HS_END));
  assign vs          = !((v_cnt >= VS_BEGIN) && (v_cnt < VS_END));
  assign frame_start = running && (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: rtl/pixel_buffer_scanout.sv
// Display-port reader of the 2-bit trace buffer: issues {x,y} addresses and
// drives VGA RGB/syncs aligned to RAM latency. Optional grid: SCANOUT_GRID_EN.
module pixel_buffer_scanout
  import scanout_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned RAM_LAT  = 2
`ifdef SCANOUT_GRID_EN
  ,
  parameter int unsigned GRID_SPACING = 64
`endif
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  output logic [18:0] oRd_Addr,
  input  logic [1:0]  iRd_Data,
  output logic [9:0]  oCurrent_X,
  output logic [8:0]  oCurrent_Y,
  output logic        oFrame_Start,
  output logic [7:0]  oVGA_R,
  output logic [7:0]  oVGA_G,
  output logic [7:0]  oVGA_B,
  output logic        oVGA_HS,
  output logic        oVGA_VS,
  output logic        oVGA_BLANK_N,
  output logic        oVGA_SYNC_N,
  output logic        oVGA_CLOCK
);

  logic [9:0] h_cnt;
  logic [8:0] v_pos;
  logic       active;
  logic       hs_raw;
  logic       vs_raw;
  logic       frame_start;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk         (iCLK),
    .rst_n       (iRST_N),
    .h_cnt       (h_cnt),
    .v_pos       (v_pos),
    .active      (active),
    .hs          (hs_raw),
    .vs          (vs_raw),
    .frame_start (frame_start)
  );

  assign oRd_Addr     = active ? {h_cnt, v_pos} : '0;
  assign oCurrent_X   = active ? h_cnt : '0;
  assign oCurrent_Y   = active ? v_pos : '0;
  assign oFrame_Start = frame_start;
  assign oVGA_SYNC_N  = 1'b0;
  assign oVGA_CLOCK   = ~iCLK;

  // Control delay line: the last stage lines up with iRd_Data.
  logic [RAM_LAT-1:0] act_d;
  logic [RAM_LAT-1:0] hs_d;
  logic [RAM_LAT-1:0] vs_d;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      act_d <= '0;
      hs_d  <= '1;
      vs_d  <= '1;
    end else begin
      act_d[0] <= active;
      hs_d[0]  <= hs_raw;
      vs_d[0]  <= vs_raw;
      for (int unsigned i = 1; i < RAM_LAT; i++) begin
        act_d[i] <= act_d[i-1];
        hs_d[i]  <= hs_d[i-1];
        vs_d[i]  <= vs_d[i-1];
      end
    end
  end

`ifdef SCANOUT_GRID_EN
  logic [9:0] x_d [RAM_LAT];
  logic [8:0] y_d [RAM_LAT];
  logic [9:0] grid_x;
  logic [8:0] grid_y;
  logic       on_grid;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int unsigned i = 0; i < RAM_LAT; i++) begin
        x_d[i] <= '0;
        y_d[i] <= '0;
      end
    end else begin
      x_d[0] <= h_cnt;
      y_d[0] <= v_pos;
      for (int unsigned i = 1; i < RAM_LAT; i++) begin
        x_d[i] <= x_d[i-1];
        y_d[i] <= y_d[i-1];
      end
    end
  end

  assign grid_x  = x_d[RAM_LAT-1];
  assign grid_y  = y_d[RAM_LAT-1];
  assign on_grid = ((32'(grid_x) % GRID_SPACING) == 32'd0) ||
                   ((32'(grid_y) % GRID_SPACING) == 32'd0) ||
                   (32'(grid_x) == GRID_CENTER_X)           ||
                   (32'(grid_y) == GRID_CENTER_Y);
`endif

  logic [23:0] pix_rgb;

  always_comb begin
    pix_rgb = palette(iRd_Data);
`ifdef SCANOUT_GRID_EN
    if ((iRd_Data == CODE_WHITE) && on_grid) begin
      pix_rgb = GRID_RGB;
    end
`endif
  end

  logic [23:0] rgb;
  logic        hs_q;
  logic        vs_q;
  logic        blank_n_q;

  // Blank gates the RAM data entirely so undriven codes never reach the DAC.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      rgb       <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
    end else begin
      hs_q      <= hs_d[RAM_LAT-1];
      vs_q      <= vs_d[RAM_LAT-1];
      blank_n_q <= act_d[RAM_LAT-1];
      rgb       <= act_d[RAM_LAT-1] ? pix_rgb : '0;
    end
  end

  assign oVGA_R       = rgb[23:16];
  assign oVGA_G       = rgb[15:8];
  assign oVGA_B       = rgb[7:0];
  assign oVGA_HS      = hs_q;
  assign oVGA_VS      = vs_q;
  assign oVGA_BLANK_N = blank_n_q;

endmodule

// File: tb/tb_pixel_buffer_scanout.sv
// Self-checking bench for pixel_buffer_scanout: behavioural 2-cycle RAM,
// cycle-index reference model and a scoreboard of expected video outputs.
`timescale 1ns/1ps
module tb_pixel_buffer_scanout;

  localparam int HT    = 800;
  localparam int HA    = 640;
  localparam int VA    = 12;
  localparam int VFP   = 2;
  localparam int VSY   = 2;
  localparam int VBP   = 3;
  localparam int VT    = VA + VFP + VSY + VBP;
  localparam int FRAME = HT * VT;
  localparam int LAT   = 3;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [18:0] rd_addr;
  logic [1:0]  rd_data;
  logic [9:0]  cur_x;
  logic [8:0]  cur_y;
  logic        frame_start;
  logic [7:0]  r, g, b;
  logic        vga_hs, vga_vs, blank_n, sync_n, vga_clk;

  pixel_buffer_scanout #(
    .H_ACTIVE (640),
    .H_FP     (16),
    .H_SYNC   (96),
    .H_BP     (48),
    .V_ACTIVE (VA),
    .V_FP     (VFP),
    .V_SYNC   (VSY),
    .V_BP     (VBP),
    .RAM_LAT  (2)
  ) dut (
    .iCLK         (clk),
    .iRST_N       (rst_n),
    .oRd_Addr     (rd_addr),
    .iRd_Data     (rd_data),
    .oCurrent_X   (cur_x),
    .oCurrent_Y   (cur_y),
    .oFrame_Start (frame_start),
    .oVGA_R       (r),
    .oVGA_G       (g),
    .oVGA_B       (b),
    .oVGA_HS      (vga_hs),
    .oVGA_VS      (vga_vs),
    .oVGA_BLANK_N (blank_n),
    .oVGA_SYNC_N  (sync_n),
    .oVGA_CLOCK   (vga_clk)
  );

  always #5 clk = ~clk;

  // Behavioural buffer port b, two cycles from address to data; junk in blank slots.
  logic [1:0] mem [1024][16];
  logic [1:0] q1, q2;
  logic       b1 = 1'b0, b2 = 1'b0;
  logic       m_act = 1'b0;
  logic [1:0] junk = 2'b11;

  always @(posedge clk) begin
    q1 <= mem[rd_addr[18:9]][rd_addr[3:0]];
    q2 <= q1;
    b1 <= m_act;
    b2 <= b1;
  end
  assign rd_data = b2 ? q2 : junk;

  typedef struct packed {
    int          due;
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        blank_n;
  } exp_t;

  exp_t sb[$];
  int   cyc    = -1;
  int   errors = 0;
  int   checks = 0;
  int   hs_low_f = 0, vs_low_f = 0, blank_f = 0, hs_low_l = 0, blank_l = 0;

  function automatic logic [23:0] exp_rgb(input int x, input int y, input logic [1:0] code);
    logic [23:0] c;
    case (code)
      2'b00:   c = 24'hFFFFFF;
      2'b01:   c = 24'h0000FF;
      2'b10:   c = 24'hFF0000;
      default: c = 24'h000000;
    endcase
`ifdef SCANOUT_GRID_EN
    if (code == 2'b00 && (x % 64 == 0 || y % 64 == 0 || x == 320 || y == 240)) c = 24'hC0C0C0;
`endif
    return c;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    int   h, v;
    bit   act;
    exp_t e;
    @(posedge clk);
    #1;
    if (!rst_n) return;
    cyc++;
    h   = cyc % HT;
    v   = (cyc / HT) % VT;
    act = (h < HA) && (v < VA);
    m_act = act;
    chk("frame_start", {63'd0, frame_start}, {63'd0, (cyc % FRAME) == 0});
    chk("addr", {rd_addr, cur_x, cur_y},
        act ? {h[9:0], v[8:0], h[9:0], v[8:0]} : 38'd0);
    chk("sync_n_clk", {sync_n, vga_clk}, {1'b0, ~clk});
    e.due     = cyc + LAT;
    e.rgb     = act ? exp_rgb(h, v, mem[h][v]) : 24'h0;
    e.hs      = !(h >= 656 && h < 752);
    e.vs      = !(v >= VA + VFP && v < VA + VFP + VSY);
    e.blank_n = act;
    sb.push_back(e);
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk($sformatf("video@%0d", cyc), {r, g, b, vga_hs, vga_vs, blank_n},
          {e.rgb, e.hs, e.vs, e.blank_n});
    end
    if (cyc >= LAT && cyc < LAT + FRAME) begin
      if (!vga_hs) hs_low_f++;
      if (!vga_vs) vs_low_f++;
      if (blank_n) blank_f++;
      if (cyc < LAT + HT) begin
        if (!vga_hs) hs_low_l++;
        if (blank_n) blank_l++;
      end
    end
  endtask

  task automatic run_to(input int target);
    int guard = 0;
    while (cyc < target && guard < 60000) begin
      step();
      guard++;
    end
    chk($sformatf("reach_cycle_%0d", target), cyc, target);
  endtask

  task automatic check_px(input int x, input int y, input int base);
    run_to(base + y * HT + x + LAT);
    chk($sformatf("px(%0d,%0d)", x, y), {blank_n, r, g, b}, {1'b1, exp_rgb(x, y, mem[x][y])});
  endtask

  task automatic check_reset_outputs(input string tag);
    chk(tag, {r, g, b, vga_hs, vga_vs, blank_n, rd_addr, frame_start},
        {24'h0, 1'b1, 1'b1, 1'b0, 19'h0, 1'b0});
  endtask

  task automatic release_reset();
    exp_t e;
    rst_n = 1'b1;
    cyc   = -1;
    m_act = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      e.due = i; e.rgb = 24'h0; e.hs = 1'b1; e.vs = 1'b1; e.blank_n = 1'b0;
      sb.push_back(e);
    end
    #1;
    chk("fs_at_release", {63'd0, frame_start}, 64'd0);
  endtask

  initial begin
    for (int x = 0; x < 1024; x++)
      for (int y = 0; y < 16; y++)
        mem[x][y] = 2'b00;
    mem[5][7] = 2'b01;
    mem[0][1] = 2'b01;
    mem[0][2] = 2'b10;
    mem[0][3] = 2'b11;

    repeat (5) step();
    check_reset_outputs("reset_hold");
    chk("reset_cur", {cur_x, cur_y}, 19'd0);
    release_reset();

    check_px(0, 0, 0);
    check_px(0, 1, 0);
    chk("pal_trace1", {r, g, b}, 24'h0000FF);
    run_to(1 * HT + 700 + LAT);
    chk("blank_junk11", {r, g, b, blank_n}, 25'd0);
    check_px(0, 2, 0);
    chk("pal_trace2", {r, g, b}, 24'hFF0000);
    check_px(0, 3, 0);
    chk("pal_special", {r, g, b}, 24'h000000);
    check_px(320, 5, 0);
`ifdef SCANOUT_GRID_EN
    chk("grid_center_x", {r, g, b}, 24'hC0C0C0);
`endif
    check_px(4, 7, 0);
    chk("left_of_blue", {r, g, b}, 24'hFFFFFF);
    check_px(5, 7, 0);
    chk("blue_at_5_7", {r, g, b}, 24'h0000FF);
    check_px(6, 7, 0);
    chk("right_of_blue", {r, g, b}, 24'hFFFFFF);
    check_px(64, 10, 0);
`ifdef SCANOUT_GRID_EN
    chk("grid_x64", {r, g, b}, 24'hC0C0C0);
`endif
    check_px(65, 10, 0);
    chk("off_grid_white", {r, g, b}, 24'hFFFFFF);

    run_to(LAT + FRAME);
    chk("hs_low_per_line", hs_low_l, 96);
    chk("blank_per_line", blank_l, HA);
    chk("hs_low_per_frame", hs_low_f, 96 * VT);
    chk("vs_low_per_frame", vs_low_f, VSY * HT);
    chk("blank_per_frame", blank_f, HA * VA);

    mem[64][10] = 2'b10;
    junk = 2'bxx;
    check_px(64, 10, FRAME);
    chk("trace_over_grid", {r, g, b}, 24'hFF0000);

    run_to(FRAME + 10 * HT + 300);
    rst_n = 1'b0;
    m_act = 1'b0;
    #1;
    check_reset_outputs("reset_async");
    sb.delete();
    repeat (5) step();
    check_reset_outputs("reset_mid_hold");
    release_reset();
    run_to(0);
    chk("restart_fs", {63'd0, frame_start}, 64'd1);
    run_to(1);
    chk("restart_x1", {rd_addr, cur_x}, {10'd1, 9'd0, 10'd1});
    check_px(0, 0, 0);
    run_to(HT + LAT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
